// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types for the data memory stage: the default word and register-address
// types, the stage FSM state encoding and the upper bound on load latency.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_W      = 16;
    localparam int RADDR_W_DEF = 4;
    localparam int LATENCY_MAX = 4;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [RADDR_W_DEF-1:0] raddr_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_DUMP,
        ST_HALTED
    } mem_state_e;

endpackage

// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
// DEPTH x DATA_W single-clock RAM. One synchronous read port (rdata_o updates
// only when re_i is high, otherwise it holds) and one write port. A read and a
// write to the same word on the same edge return the old contents.
// Ports:
//   clk      clock
//   re_i     read enable
//   raddr_i  read address
//   rdata_o  registered read data
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
// ---------------------------------------------------------------------------
module data_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_stage.sv
// ---------------------------------------------------------------------------
// data_mem_stage
// Pipeline memory stage between execute and writeback. Owns a DEPTH-word data
// RAM, sweeps it to zero after reset, executes loads (LATENCY cycles) and
// stores (single cycle), reports out-of-range accesses, honours flush, and on
// a rising halt streams the first DUMP_WORDS words out.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   in_valid / in_ready         op handshake from execute
//   is_mem_read/is_mem_write    op type (both set = read-before-write)
//   is_reg_write, rd_addr       load writeback request and destination
//   base, offset, st_data       address operands and store data
//   flush                       squash current op and in-flight load
//   halt                        rising edge starts the dump
//   wb_valid/wb_value/wb_reg_addr   load result
//   fault/fault_addr            range-fault pulse and sticky address
//   dump_valid/dump_addr/dump_data  dump stream
// ---------------------------------------------------------------------------
module data_mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 64,
    parameter int RADDR_W    = 4,
    parameter int LATENCY    = 1,
    parameter int DUMP_WORDS = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_mem_read,
    input  logic               is_mem_write,
    input  logic               is_reg_write,
    input  logic [DATA_W-1:0]  base,
    input  logic [DATA_W-1:0]  offset,
    input  logic [DATA_W-1:0]  st_data,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               flush,
    input  logic               halt,
    output logic               wb_valid,
    output logic [DATA_W-1:0]  wb_value,
    output logic [RADDR_W-1:0] wb_reg_addr,
    output logic               fault,
    output logic [DATA_W-1:0]  fault_addr,
    output logic               dump_valid,
    output logic [DATA_W-1:0]  dump_addr,
    output logic [DATA_W-1:0]  dump_data
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W = $clog2(LATENCY_MAX);
    localparam logic [DATA_W:0]  DEPTH_L  = (DATA_W+1)'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

    mem_state_e         state_q, state_d;
    logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]  dump_cnt_q, dump_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               pend_wb_q, pend_wb_d;
    logic               dump_pend_q, dump_pend_d;
    logic               halt_q;
    logic               wb_valid_q, wb_valid_d;
    logic [RADDR_W-1:0] pend_rd_q;
    logic [DATA_W-1:0]  wb_hold_q;
    logic [RADDR_W-1:0] rd_hold_q;
    logic               fault_q;
    logic [DATA_W-1:0]  fault_addr_q;
    logic               dump_valid_q, dump_valid_d;
    logic [DATA_W-1:0]  dump_addr_q, dump_addr_d;

    logic [DATA_W-1:0]  addr;
    logic               addr_fault, accept, acc_load, acc_store, acc_fault, halt_rise;

    logic               ram_re, ram_we;
    logic [AW-1:0]      ram_raddr, ram_waddr;
    logic [DATA_W-1:0]  ram_wdata, ram_rdata;

    assign addr       = base + offset;
    assign addr_fault = ({1'b0, addr} >= DEPTH_L);
    assign in_ready   = (state_q == ST_IDLE);
    assign accept     = in_valid & in_ready & ~flush;
    assign acc_load   = accept & is_mem_read  & ~addr_fault;
    assign acc_store  = accept & is_mem_write & ~addr_fault;
    assign acc_fault  = accept & (is_mem_read | is_mem_write) & addr_fault;
    assign halt_rise  = halt & ~halt_q;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        dump_cnt_d   = dump_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        pend_wb_d    = pend_wb_q;
        dump_pend_d  = dump_pend_q;
        wb_valid_d   = 1'b0;
        dump_valid_d = 1'b0;
        dump_addr_d  = dump_addr_q;
        ram_re       = acc_load;
        ram_raddr    = addr[AW-1:0];
        ram_we       = acc_store;
        ram_waddr    = addr[AW-1:0];
        ram_wdata    = st_data;

        unique case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A multi-cycle load accepted together with a halt rise goes
                // to LOAD first and remembers the dump request.
                if (acc_load && LATENCY > 1) begin
                    state_d     = ST_LOAD;
                    lat_cnt_d   = LAT_W'(1);
                    pend_wb_d   = is_reg_write;
                    dump_pend_d = halt_rise;
                end else begin
                    if (acc_load) begin
                        wb_valid_d = is_reg_write;
                    end
                    if (halt_rise) begin
                        state_d = ST_DUMP;
                    end
                end
            end
            ST_LOAD: begin
                if (flush || lat_cnt_q == LAT_LAST) begin
                    wb_valid_d  = pend_wb_q & ~flush;
                    state_d     = (dump_pend_q || halt_rise) ? ST_DUMP : ST_IDLE;
                    dump_pend_d = 1'b0;
                    lat_cnt_d   = '0;
                end else begin
                    lat_cnt_d   = lat_cnt_q + LAT_W'(1);
                    dump_pend_d = dump_pend_q | halt_rise;
                end
            end
            ST_DUMP: begin
                ram_re       = 1'b1;
                ram_raddr    = dump_cnt_q[AW-1:0];
                dump_valid_d = 1'b1;
                dump_addr_d  = dump_cnt_q;
                dump_cnt_d   = dump_cnt_q + DATA_W'(1);
                if (dump_cnt_q == DATA_W'(DUMP_WORDS - 1)) begin
                    dump_cnt_d = '0;
                    state_d    = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        if (!rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            dump_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            pend_wb_q    <= 1'b0;
            dump_pend_q  <= 1'b0;
            halt_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            pend_rd_q    <= '0;
            wb_hold_q    <= '0;
            rd_hold_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            dump_cnt_q   <= dump_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            pend_wb_q    <= pend_wb_d;
            dump_pend_q  <= dump_pend_d;
            halt_q       <= halt;
            wb_valid_q   <= wb_valid_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            fault_q      <= acc_fault;
            if (acc_fault) begin
                fault_addr_q <= addr;
            end
            if (acc_load) begin
                pend_rd_q <= rd_addr;
            end
            // Capture the presented result so wb outputs hold after the pulse.
            if (wb_valid_q) begin
                wb_hold_q <= ram_rdata;
                rd_hold_q <= pend_rd_q;
            end
        end
    end

    // The RAM read register is shared by loads and dump; it only reaches the
    // outputs while the matching valid is high, held copies cover the rest.
    assign wb_valid    = wb_valid_q;
    assign wb_value    = wb_valid_q ? ram_rdata : wb_hold_q;
    assign wb_reg_addr = wb_valid_q ? pend_rd_q : rd_hold_q;
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    assign dump_valid  = dump_valid_q;
    assign dump_addr   = dump_addr_q;
    assign dump_data   = dump_valid_q ? ram_rdata : '0;

    data_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata)
    );

endmodule

// File: tb/tb_data_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_data_mem_stage
// Directed bench for data_mem_stage with LATENCY=3, DEPTH=64, DUMP_WORDS=20.
// ---------------------------------------------------------------------------
module tb_data_mem_stage;
    import mem_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   in_valid, in_ready;
    logic   is_mem_read, is_mem_write, is_reg_write;
    word_t  base, offset, st_data;
    raddr_t rd_addr;
    logic   flush, halt;
    logic   wb_valid;
    word_t  wb_value;
    raddr_t wb_reg_addr;
    logic   fault;
    word_t  fault_addr;
    logic   dump_valid;
    word_t  dump_addr, dump_data;

    int vec_n = 0;
    int err_n = 0;

    always #5 clk = ~clk;

    data_mem_stage #(
        .DATA_W     (16),
        .DEPTH      (64),
        .RADDR_W    (4),
        .LATENCY    (3),
        .DUMP_WORDS (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .is_mem_read  (is_mem_read),
        .is_mem_write (is_mem_write),
        .is_reg_write (is_reg_write),
        .base         (base),
        .offset       (offset),
        .st_data      (st_data),
        .rd_addr      (rd_addr),
        .flush        (flush),
        .halt         (halt),
        .wb_valid     (wb_valid),
        .wb_value     (wb_value),
        .wb_reg_addr  (wb_reg_addr),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .dump_valid   (dump_valid),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic rd, input logic wr, input logic rw,
                      input word_t b, input word_t o, input word_t d, input raddr_t ra);
        in_valid     = 1'b1;
        is_mem_read  = rd;
        is_mem_write = wr;
        is_reg_write = rw;
        base         = b;
        offset       = o;
        st_data      = d;
        rd_addr      = ra;
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        is_mem_read  = 1'b0;
        is_mem_write = 1'b0;
        is_reg_write = 1'b0;
    endtask

    // Counts cycles spent in the clear sweep; must be exactly 64.
    task automatic clear_sweep(input string tag);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk(tag, n, 64);
    endtask

    task automatic wait_dump(input string tag);
        int n = 0;
        while (!dump_valid && n < 10) begin
            tick();
            n++;
        end
        chk(tag, dump_valid, 1);
    endtask

    // Single LATENCY=3 load; checks the stall window and the result.
    task automatic load_chk(input string tag, input word_t b, input word_t o,
                            input raddr_t ra, input word_t exp);
        op(1'b1, 1'b0, 1'b1, b, o, 16'h0, ra);
        tick();
        idle_in();
        chk({tag, "_stall0"}, {in_ready, wb_valid}, 2'b00);
        tick();
        chk({tag, "_stall1"}, {in_ready, wb_valid}, 2'b00);
        tick();
        chk({tag, "_wbv"}, {in_ready, wb_valid}, 2'b11);
        chk({tag, "_val"}, wb_value, exp);
        chk({tag, "_reg"}, wb_reg_addr, ra);
        tick();
        chk({tag, "_pulse"}, wb_valid, 0);
        chk({tag, "_hold"}, wb_value, exp);
    endtask

    initial begin
        logic [15:0] exp_d [6];
        exp_d[0] = 16'h0000; exp_d[1] = 16'h000A; exp_d[2] = 16'h0000;
        exp_d[3] = 16'h0000; exp_d[4] = 16'h0000; exp_d[5] = 16'hBEEF;

        rst = 1'b0; flush = 1'b0; halt = 1'b0;
        base = '0; offset = '0; st_data = '0; rd_addr = '0;
        idle_in();
        tick();
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbval", wb_value, 0);
        chk("rst_fault", {fault, fault_addr}, 0);
        chk("rst_dump", {dump_valid, dump_addr, dump_data}, 0);

        // Clear sweep with in_valid held high.
        rst = 1'b1;
        in_valid = 1'b1;
        clear_sweep("clear_len");
        chk("clear_ready", in_ready, 1);
        idle_in();

        // Dump straight after the sweep: all zeros.
        halt = 1'b1;
        tick();
        wait_dump("dump0_start");
        for (int b = 0; b < 20; b++) begin
            chk("dump0_valid", dump_valid, 1);
            chk("dump0_addr", dump_addr, b);
            chk("dump0_data", dump_data, 0);
            tick();
        end
        chk("dump0_end", dump_valid, 0);
        chk("halted_ready", in_ready, 0);
        halt = 1'b0;
        tick();
        chk("unhalt_ready", in_ready, 1);

        // Store 0xBEEF to 3+2, then load back with 3-cycle latency.
        op(1'b0, 1'b1, 1'b0, 16'd3, 16'd2, 16'hBEEF, 4'd0);
        tick();
        chk("store_nostall", in_ready, 1);
        load_chk("ld5", 16'd5, 16'd0, 4'd9, 16'hBEEF);

        // Read-before-write on the same op.
        op(1'b0, 1'b1, 1'b0, 16'd7, 16'd0, 16'h0011, 4'd0);
        tick();
        op(1'b1, 1'b1, 1'b1, 16'd7, 16'd0, 16'h2222, 4'd3);
        tick();
        idle_in();
        tick();
        tick();
        chk("rbw_wbv", wb_valid, 1);
        chk("rbw_old", wb_value, 16'h0011);
        chk("rbw_reg", wb_reg_addr, 4'd3);
        tick();
        load_chk("ld7", 16'd7, 16'd0, 4'd4, 16'h2222);

        // Out-of-range load at 60+10.
        op(1'b1, 1'b0, 1'b1, 16'd60, 16'd10, 16'h0, 4'd1);
        tick();
        idle_in();
        chk("fld_fault", fault, 1);
        chk("fld_addr", fault_addr, 16'd70);
        chk("fld_wbv", wb_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fld_nowb", {wb_valid, fault}, 2'b00);
        end
        chk("fld_sticky", fault_addr, 16'd70);

        // Out-of-range store at 0xFFFF; the word it would alias to stays 0.
        op(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'd0, 16'h1234, 4'd0);
        tick();
        idle_in();
        chk("fst_fault", fault, 1);
        chk("fst_addr", fault_addr, 16'hFFFF);
        tick();
        chk("fst_pulse", fault, 0);
        load_chk("ld63", 16'd63, 16'd0, 4'd2, 16'h0000);

        // First out-of-range word.
        op(1'b0, 1'b1, 1'b0, 16'd32, 16'd32, 16'h5555, 4'd0);
        tick();
        idle_in();
        chk("f64_fault", fault, 1);
        chk("f64_addr", fault_addr, 16'd64);
        tick();

        // Address wraps modulo 2**16: 0xFFFF + 6 == 5.
        load_chk("ldwrap", 16'hFFFF, 16'd6, 4'd15, 16'hBEEF);

        // Flush blocks acceptance: the store is dropped.
        op(1'b0, 1'b1, 1'b0, 16'd10, 16'd0, 16'hAAAA, 4'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        load_chk("ld10", 16'd10, 16'd0, 4'd6, 16'h0000);

        // Flush kills an in-flight load.
        op(1'b1, 1'b0, 1'b1, 16'd5, 16'd0, 16'h0, 4'd8);
        tick();
        idle_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", in_ready, 1);
        chk("flush_wbv0", wb_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_nowb", wb_valid, 0);
        end

        // Dump with mem[1]=10, reset at beat 5.
        op(1'b0, 1'b1, 1'b0, 16'd1, 16'd0, 16'd10, 4'd0);
        tick();
        idle_in();
        halt = 1'b1;
        tick();
        wait_dump("dump1_start");
        for (int b = 0; b < 6; b++) begin
            chk("dump1_addr", dump_addr, b);
            chk("dump1_data", dump_data, exp_d[b]);
            if (b < 5) tick();
        end
        rst = 1'b0;
        tick();
        chk("dump1_abort", dump_valid, 0);
        chk("dump1_rst_ready", in_ready, 0);
        rst = 1'b1;
        halt = 1'b0;
        clear_sweep("clear2_len");
        load_chk("ld5_clr", 16'd5, 16'd0, 4'd7, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
